// File: rtl/serial_sub_pkg.sv
// Shared types and sizing helpers for the bit-serial subtract controller.
package serial_sub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int unsigned DEF_WIDTH = 8;

    // Bit counter width for a given operand width; sized so cnt never wraps within one operation.
    function automatic int unsigned cnt_width(input int unsigned width);
        return (width < 2) ? 1 : $clog2(width);
    endfunction

    localparam int unsigned DEF_CNT_W = cnt_width(DEF_WIDTH);

endpackage

// File: rtl/full_sub.sv
// 1-bit full subtractor cell: diff = a - b - bin, bout = borrow out.
module full_sub (
    input  logic a,
    input  logic bin,
    input  logic b,
    output logic bout,
    output logic diff
);

    assign diff = a ^ b ^ bin;
    assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_sub_ctrl.sv
// Bit-serial subtractor: one full_sub cell stepped LSB first over WIDTH bits,
// with a start/busy/done handshake and the borrow carried in a flop.
module serial_sub_ctrl
    import serial_sub_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout
);

    localparam int unsigned CNT_W = cnt_width(WIDTH);

    state_t             state;
    logic [WIDTH-1:0]   a_sh;
    logic [WIDTH-1:0]   b_sh;
    logic               brw;
    logic [CNT_W-1:0]   cnt;
    logic               cell_diff;
    logic               cell_bout;

    full_sub u_cell (
        .a    (a_sh[0]),
        .bin  (brw),
        .b    (b_sh[0]),
        .bout (cell_bout),
        .diff (cell_diff)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            diff  <= '0;
            bout  <= 1'b0;
            cnt   <= '0;
            a_sh  <= '0;
            b_sh  <= '0;
            brw   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sh  <= a;
                        b_sh  <= b;
                        brw   <= bin;
                        cnt   <= '0;
                        diff  <= '0;
                        bout  <= 1'b0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end
                end
                RUN: begin
                    // Result bits enter at the MSB so the first bit lands in diff[0] after WIDTH shifts.
                    diff <= {cell_diff, diff[WIDTH-1:1]};
                    a_sh <= a_sh >> 1;
                    b_sh <= b_sh >> 1;
                    brw  <= cell_bout;
                    if (cnt == CNT_W'(WIDTH - 1)) begin
                        bout  <= cell_bout;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_sub_ctrl.sv
// Self-checking bench for serial_sub_ctrl (WIDTH=8): directed table, corner sequences, random.
module tb_serial_sub_ctrl;

    localparam int unsigned W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin;
    logic         busy;
    logic         done;
    logic [W-1:0] diff;
    logic         bout;

    serial_sub_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .diff  (diff),
        .bout  (bout)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         bin;
        logic [W-1:0] diff;
        logic         bout;
    } vec_t;

    vec_t         tbl [5];
    logic [W:0]   sb_q [$];
    int           n_checks = 0;
    int           n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare the DUT result against the oldest scoreboard entry.
    task automatic pop_check(input string name);
        logic [W:0] exp;
        if (sb_q.size() == 0) begin
            check({name, "_sb_empty"}, 32'(1), 32'(0));
        end else begin
            exp = sb_q.pop_front();
            check(name, 32'({bout, diff}), 32'(exp));
        end
    endtask

    // Launch one operation and wait for done; optionally scramble inputs while running.
    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tbin,
                          input logic [W:0] exp, input bit toggle, input bit detail);
        int k;
        int busy_cnt;
        bit seen;
        logic [W-1:0] held;
        start = 1'b1; a = ta; b = tb; bin = tbin;
        sb_q.push_back(exp);
        @(negedge clk);
        start = 1'b0;
        if (detail) begin
            check("accept_busy", 32'(busy), 32'(1));
            check("accept_diff_clr", 32'(diff), 32'(0));
            check("accept_bout_clr", 32'(bout), 32'(0));
        end
        k = 0; busy_cnt = 0; seen = 1'b0;
        while (k < W + 4) begin
            if (busy) busy_cnt++;
            if (toggle) begin
                a = W'($urandom); b = W'($urandom); bin = 1'($urandom); start = 1'($urandom);
            end
            @(negedge clk);
            k++;
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        start = 1'b0;
        if (!seen) begin
            check("done_timeout", 32'(0), 32'(1));
            void'(sb_q.pop_front());
        end else begin
            pop_check("result");
            if (detail) begin
                check("latency", 32'(k), 32'(W));
                check("busy_cycles", 32'(busy_cnt), 32'(W));
                check("busy_at_done", 32'(busy), 32'(0));
                held = diff;
                for (int i = 0; i < 3; i++) begin
                    @(negedge clk);
                    check("done_single", 32'(done), 32'(0));
                end
                check("diff_held", 32'(diff), 32'(held));
                check("bout_held", 32'(bout), 32'(exp[W]));
            end else begin
                @(negedge clk);
            end
        end
    endtask

    initial begin
        logic [W-1:0] ra, rb;
        logic         rbin;
        int           k;
        int           t1, t2, ndone;

        tbl[0] = '{8'h5A, 8'h21, 1'b0, 8'h39, 1'b0};
        tbl[1] = '{8'h10, 8'h20, 1'b0, 8'hF0, 1'b1};
        tbl[2] = '{8'h00, 8'h00, 1'b1, 8'hFF, 1'b1};
        tbl[3] = '{8'hFF, 8'hFF, 1'b0, 8'h00, 1'b0};
        tbl[4] = '{8'h80, 8'h01, 1'b0, 8'h7F, 1'b0};

        rst = 1'b1; start = 1'b1; a = '0; b = '0; bin = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("rst_busy", 32'(busy), 32'(0));
        check("rst_done", 32'(done), 32'(0));
        check("rst_diff", 32'(diff), 32'(0));
        check("rst_bout", 32'(bout), 32'(0));
        rst = 1'b0; start = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 5; i++)
            run_op(tbl[i].a, tbl[i].b, tbl[i].bin, {tbl[i].bout, tbl[i].diff}, 1'b0, 1'b1);

        // Input isolation: scramble everything while running.
        run_op(tbl[3].a, tbl[3].b, tbl[3].bin, {tbl[3].bout, tbl[3].diff}, 1'b1, 1'b1);

        // Back-to-back with start held: second op picked up on the IDLE re-accept.
        start = 1'b1; a = 8'h05; b = 8'h03; bin = 1'b0;
        sb_q.push_back({1'b0, 8'h02});
        sb_q.push_back({1'b1, 8'hFE});
        @(negedge clk);
        a = 8'h03; b = 8'h05;
        k = 0; ndone = 0; t1 = 0; t2 = 0;
        while (k < 30 && ndone < 2) begin
            @(negedge clk);
            k++;
            if (done) begin
                ndone++;
                if (ndone == 1) t1 = k; else t2 = k;
                pop_check("b2b_result");
                if (ndone == 2) start = 1'b0;
            end
        end
        start = 1'b0;
        check("b2b_ndone", 32'(ndone), 32'(2));
        check("b2b_first", 32'(t1), 32'(W));
        check("b2b_gap", 32'(t2 - t1), 32'(W + 2));
        while (sb_q.size() > 0) void'(sb_q.pop_front());
        repeat (3) @(negedge clk);

        // Reset on the third RUN cycle.
        start = 1'b1; a = 8'hAA; b = 8'h55; bin = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_busy", 32'(busy), 32'(0));
        check("midrst_diff", 32'(diff), 32'(0));
        check("midrst_bout", 32'(bout), 32'(0));
        ndone = 0;
        for (int i = 0; i < W + 2; i++) begin
            if (done) ndone++;
            @(negedge clk);
        end
        check("midrst_no_done", 32'(ndone), 32'(0));
        run_op(8'h80, 8'h01, 1'b0, {1'b0, 8'h7F}, 1'b0, 1'b1);

        for (int i = 0; i < 1000; i++) begin
            ra = W'($urandom); rb = W'($urandom); rbin = 1'($urandom);
            run_op(ra, rb, rbin, {1'b0, ra} - {1'b0, rb} - (W + 1)'(rbin), 1'b0, 1'b0);
        end

        check("sb_drained", 32'(sb_q.size()), 32'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
